uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port tick_rx_i, input, 1, one-clk pulse at 16x baud from the baud generator.
REQ-004 SHALL have port rx_i, input, 1, asynchronous serial line; idle high.
REQ-005 SHALL have port data_bits_i, input, 2, word length: 00=5, 01=6, 10=7, 11=8.
REQ-006 SHALL have port parity_en_i, input, 1, 1 = parity bit follows data.
REQ-007 SHALL have port parity_odd_i, input, 1, 1 = odd parity, 0 = even parity.
REQ-008 SHALL have port rd_i, input, 1, consumer acknowledge of held word.
REQ-009 SHALL have port data_o, output, 8, received word, LSB-aligned; unused upper bits 0.
REQ-010 SHALL have port valid_o, output, 1, data_o holds an unread word.
REQ-011 SHALL have port parity_err_o, output, 1, parity mismatch on held word.
REQ-012 SHALL have port frame_err_o, output, 1, stop bit sampled low on held word.
REQ-013 SHALL have port overrun_o, output, 1, a word was overwritten before being read.
REQ-014 SHALL have port busy_o, output, 1, 1 in any state other than IDLE.

Function
REQ-015 SHALL pass rx_i through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-017 SHALL, in IDLE, detect a 1->0 transition of the synchronized line, clear the 4-bit tick counter, latch data_bits_i/parity_en_i/parity_odd_i, and enter START.
REQ-018 SHALL advance the tick counter only on cycles with tick_rx_i=1, wrapping 15->0; each bit occupies counts 0..15 and is sampled at count 7 (bit centre).
REQ-019 SHALL, in START at the count-7 sample, return to IDLE if the line is 1 (false start); otherwise enter DATA when count 15 completes.
REQ-020 SHALL, in DATA, shift in bits LSB first; after the latched number of bits, enter PARITY if parity enabled, else STOP, at count-15 completion.
REQ-021 SHALL compute parity error as XOR of data bits and parity bit equal to 1 (even) or 0 (odd).
REQ-022 SHALL, in STOP at the sample point, set frame error if the line is 0, load data_o and error flags, assert valid_o on the next clk, and return to IDLE immediately (no wait for end of stop bit).
REQ-023 SHALL hold valid_o, data_o, parity_err_o, frame_err_o until rd_i=1 while valid_o=1, which clears valid_o and all three error flags on the next clk.
REQ-024 SHALL, when a word completes while valid_o=1 and rd_i=0, overwrite data_o and error flags, keep valid_o=1, and set overrun_o.
REQ-025 SHALL, when a word completes in the same cycle as rd_i=1, load the new word, keep valid_o=1, and not set overrun_o.
REQ-026 SHALL clear overrun_o only on rd_i=1 with valid_o=1 and no concurrent completion.
REQ-027 SHALL ignore rd_i while valid_o=0.
REQ-028 SHALL ignore changes to configuration inputs mid-frame.

Reset
REQ-029 SHALL, on reset=1 at a clk edge, enter IDLE, clear tick counter, bit counter and shift register, set both synchronizer flops to 1, and drive data_o=0, valid_o=0, parity_err_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
REQ-030 SHALL abort any frame in progress on reset without producing valid_o.

Configuration
REQ-031 SHALL, with macro UART_RX_MAJORITY_EN defined, sample each bit (start, data, parity, stop) as 2-of-3 majority of counts 6, 7, 8, deciding at count 8.
REQ-032 SHALL, without UART_RX_MAJORITY_EN, use the single count-7 sample; all other behaviour identical.

Verification
REQ-033 SHALL cover: 8N1 frame 0xA5 at 16x ticks -> valid_o=1, data_o=0xA5, all error flags 0.
REQ-034 SHALL cover: 7-bit, even parity, data 0x41, wrong parity bit -> data_o=0x41, parity_err_o=1.
REQ-035 SHALL cover: 8N1 0x3C with stop bit driven 0 -> frame_err_o=1, data_o=0x3C.
REQ-036 SHALL cover: 4-tick low glitch in IDLE -> return to IDLE, no valid_o, busy_o back to 0.
REQ-037 SHALL cover: frames 0x11 then 0x22 with no rd_i -> data_o=0x22, overrun_o=1; rd_i -> valid_o=0, overrun_o=0.
REQ-038 SHALL cover: reset asserted mid-DATA -> next clk all outputs 0, subsequent 0x5A frame received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 5-8 data bits, optional parity, one-word holding register.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 vote of counts 6/7/8 instead of the single count-7 sample.
module uart_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_rx_i,
  input  logic       rx_i,
  input  logic [1:0] data_bits_i,
  input  logic       parity_en_i,
  input  logic       parity_odd_i,
  input  logic       rd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e     state_q, state_d;
  logic       sync1_q, sync2_q, rxPrev_q;
  logic [3:0] tickCnt_q, tickCnt_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [2:0] lastBit_q, lastBit_d;
  logic [7:0] shiftReg_q, shiftReg_d;
  logic       parityAcc_q, parityAcc_d;
  logic       parErr_q, parErr_d;
  logic       parityEn_q, parityEn_d;
  logic       parityOdd_q, parityOdd_d;

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       parityErr_q, parityErr_d;
  logic       frameErr_q, frameErr_d;
  logic       overrun_q, overrun_d;

  logic       sampleEn, sampleBit, bitDone;
  logic       complete, frameErrNext;

  assign bitDone = tick_rx_i && (tickCnt_q == 4'd15);

`ifdef UART_RX_MAJORITY_EN
  logic samp6_q, samp7_q, samp6_d, samp7_d;

  always_comb begin
    samp6_d = samp6_q;
    samp7_d = samp7_q;
    if (tick_rx_i && (tickCnt_q == 4'd6)) samp6_d = sync2_q;
    if (tick_rx_i && (tickCnt_q == 4'd7)) samp7_d = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp6_q <= 1'b1;
      samp7_q <= 1'b1;
    end else begin
      samp6_q <= samp6_d;
      samp7_q <= samp7_d;
    end
  end

  // The third vote is the live count-8 value, so the decision lands on count 8.
  assign sampleEn  = tick_rx_i && (tickCnt_q == 4'd8);
  assign sampleBit = (samp6_q & samp7_q) | (samp6_q & sync2_q) | (samp7_q & sync2_q);
`else
  assign sampleEn  = tick_rx_i && (tickCnt_q == 4'd7);
  assign sampleBit = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rxPrev_q    <= 1'b1;
      tickCnt_q   <= 4'd0;
      bitCnt_q    <= 3'd0;
      lastBit_q   <= 3'd7;
      shiftReg_q  <= 8'd0;
      parityAcc_q <= 1'b0;
      parErr_q    <= 1'b0;
      parityEn_q  <= 1'b0;
      parityOdd_q <= 1'b0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= rx_i;
      sync2_q     <= sync1_q;
      rxPrev_q    <= sync2_q;
      tickCnt_q   <= tickCnt_d;
      bitCnt_q    <= bitCnt_d;
      lastBit_q   <= lastBit_d;
      shiftReg_q  <= shiftReg_d;
      parityAcc_q <= parityAcc_d;
      parErr_q    <= parErr_d;
      parityEn_q  <= parityEn_d;
      parityOdd_q <= parityOdd_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      parityErr_q <= parityErr_d;
      frameErr_q  <= frameErr_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tickCnt_d    = tickCnt_q;
    bitCnt_d     = bitCnt_q;
    lastBit_d    = lastBit_q;
    shiftReg_d   = shiftReg_q;
    parityAcc_d  = parityAcc_q;
    parErr_d     = parErr_q;
    parityEn_d   = parityEn_q;
    parityOdd_d  = parityOdd_q;
    complete     = 1'b0;
    frameErrNext = 1'b0;

    if ((state_q != IDLE) && tick_rx_i) tickCnt_d = tickCnt_q + 4'd1;

    case (state_q)
      IDLE: begin
        tickCnt_d = 4'd0;
        // Edge detect rather than level, so a low stop bit cannot retrigger a frame.
        if (rxPrev_q && !sync2_q) begin
          state_d     = START;
          lastBit_d   = {1'b0, data_bits_i} + 3'd4;
          parityEn_d  = parity_en_i;
          parityOdd_d = parity_odd_i;
          bitCnt_d    = 3'd0;
          shiftReg_d  = 8'd0;
          parityAcc_d = 1'b0;
          parErr_d    = 1'b0;
        end
      end
      START: begin
        if (sampleEn && sampleBit) state_d = IDLE;
        else if (bitDone)          state_d = DATA;
      end
      DATA: begin
        if (sampleEn) begin
          shiftReg_d[bitCnt_q] = sampleBit;
          parityAcc_d          = parityAcc_q ^ sampleBit;
        end
        if (bitDone) begin
          if (bitCnt_q == lastBit_q) state_d = parityEn_q ? PARITY : STOP;
          else                       bitCnt_d = bitCnt_q + 3'd1;
        end
      end
      PARITY: begin
        if (sampleEn) parErr_d = parityAcc_q ^ sampleBit ^ parityOdd_q;
        if (bitDone)  state_d  = STOP;
      end
      STOP: begin
        if (sampleEn) begin
          complete     = 1'b1;
          frameErrNext = ~sampleBit;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: a completing word always wins over a concurrent read.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    parityErr_d = parityErr_q;
    frameErr_d  = frameErr_q;
    overrun_d   = overrun_q;
    if (complete) begin
      data_d      = shiftReg_q;
      parityErr_d = parErr_q;
      frameErr_d  = frameErrNext;
      valid_d     = 1'b1;
      if (valid_q && !rd_i) overrun_d = 1'b1;
    end else if (rd_i && valid_q) begin
      valid_d     = 1'b0;
      parityErr_d = 1'b0;
      frameErr_d  = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = parityErr_q;
  assign frame_err_o  = frameErr_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are queued as expected words when driven
// and compared when the receiver presents them.
module tb_uart_rx;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } word_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_rx_i;
  logic       rx_i;
  logic [1:0] data_bits_i;
  logic       parity_en_i;
  logic       parity_odd_i;
  logic       rd_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int    errors = 0;
  int    checks = 0;
  int    tickDiv = 0;
  word_t sbQ[$];

  uart_rx dut (
    .clk         (clk),
    .reset       (reset),
    .tick_rx_i   (tick_rx_i),
    .rx_i        (rx_i),
    .data_bits_i (data_bits_i),
    .parity_en_i (parity_en_i),
    .parity_odd_i(parity_odd_i),
    .rd_i        (rd_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .parity_err_o(parity_err_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // 16x tick is one clk in four, so one bit lasts 64 clks.
  always @(negedge clk) begin
    tickDiv   = (tickDiv + 1) % 4;
    tick_rx_i = (tickDiv == 0);
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic driveBit(input logic v);
    rx_i = v;
    repeat (64) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int nbits, input logic pen,
                               input logic podd, input logic badPar, input logic stopV,
                               input logic scramble);
    word_t      w;
    logic [7:0] mask;
    logic       pb;
    mask         = 8'hFF >> (8 - nbits);
    data_bits_i  = 2'(nbits - 5);
    parity_en_i  = pen;
    parity_odd_i = podd;
    w.data = d & mask;
    w.pe   = pen & badPar;
    w.fe   = ~stopV;
    pb     = (^w.data) ^ podd ^ badPar;
    sbQ.push_back(w);
    driveBit(1'b0);
    if (scramble) begin
      data_bits_i  = ~data_bits_i;
      parity_en_i  = ~pen;
      parity_odd_i = ~podd;
    end
    for (int i = 0; i < nbits; i++) driveBit(w.data[i]);
    if (pen) driveBit(pb);
    driveBit(stopV);
    rx_i = 1'b1;
  endtask

  task automatic waitValid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (valid_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Older queued words are the ones a later completion overwrote.
  task automatic popExpected(output word_t e, output bit ov);
    ov = (sbQ.size() > 1);
    if (sbQ.size() == 0) e = '0;
    else                 e = sbQ[$];
    sbQ.delete();
  endtask

  task automatic readWord;
    rd_i = 1'b1;
    @(negedge clk);
    rd_i = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data_o !== 8'h00)     begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", data_o); end
    checks++; if (valid_o !== 1'b0)     begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_pe: got %b expected 0", parity_err_o); end
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_fe: got %b expected 0", frame_err_o); end
    checks++; if (overrun_o !== 1'b0)   begin errors++; $display("[TB] FAIL reset_ov: got %b expected 0", overrun_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_8n1;
    word_t e; bit ok, eov;
    applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitValid(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL 8n1_valid: valid_o=%b expected 1 within bound", valid_o); end
    popExpected(e, eov);
    checks++; if (data_o !== e.data)      begin errors++; $display("[TB] FAIL 8n1_data: got %h expected %h", data_o, e.data); end
    checks++; if (parity_err_o !== e.pe)  begin errors++; $display("[TB] FAIL 8n1_pe: got %b expected %b", parity_err_o, e.pe); end
    checks++; if (frame_err_o !== e.fe)   begin errors++; $display("[TB] FAIL 8n1_fe: got %b expected %b", frame_err_o, e.fe); end
    checks++; if (overrun_o !== eov)      begin errors++; $display("[TB] FAIL 8n1_ov: got %b expected %b", overrun_o, eov); end
    readWord();
    checks++; if (valid_o !== 1'b0)       begin errors++; $display("[TB] FAIL 8n1_read: valid_o=%b expected 0", valid_o); end
    readWord();
    checks++; if (data_o !== e.data)      begin errors++; $display("[TB] FAIL 8n1_idle_rd: data_o=%h expected %h held", data_o, e.data); end
  endtask

  task automatic test_parity;
    logic [7:0] dTab[3]   = '{8'h41, 8'hFF, 8'h2A};
    int         nTab[3]   = '{7, 5, 6};
    logic       oddTab[3] = '{1'b0, 1'b1, 1'b1};
    logic       badTab[3] = '{1'b1, 1'b0, 1'b1};
    word_t e; bit ok, eov;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(dTab[k], nTab[k], 1'b1, oddTab[k], badTab[k], 1'b1, 1'b0);
      waitValid(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL parity%0d_valid: valid_o=%b expected 1", k, valid_o); end
      popExpected(e, eov);
      checks++; if (data_o !== e.data)     begin errors++; $display("[TB] FAIL parity%0d_data: got %h expected %h", k, data_o, e.data); end
      checks++; if (parity_err_o !== e.pe) begin errors++; $display("[TB] FAIL parity%0d_pe: got %b expected %b", k, parity_err_o, e.pe); end
      checks++; if (frame_err_o !== e.fe)  begin errors++; $display("[TB] FAIL parity%0d_fe: got %b expected %b", k, frame_err_o, e.fe); end
      readWord();
      checks++; if (parity_err_o !== 1'b0) begin errors++; $display("[TB] FAIL parity%0d_clr: parity_err_o=%b expected 0", k, parity_err_o); end
    end
  endtask

  task automatic test_frame_err;
    word_t e; bit ok, eov;
    applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitValid(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ferr_valid: valid_o=%b expected 1", valid_o); end
    popExpected(e, eov);
    checks++; if (data_o !== e.data)    begin errors++; $display("[TB] FAIL ferr_data: got %h expected %h", data_o, e.data); end
    checks++; if (frame_err_o !== e.fe) begin errors++; $display("[TB] FAIL ferr_fe: got %b expected %b", frame_err_o, e.fe); end
    repeat (128) @(negedge clk);
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("[TB] FAIL ferr_idle: busy_o=%b expected 0", busy_o); end
    readWord();
    checks++; if (frame_err_o !== 1'b0) begin errors++; $display("[TB] FAIL ferr_clr: frame_err_o=%b expected 0", frame_err_o); end
  endtask

  task automatic test_glitch;
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    checks++; if (busy_o !== 1'b1)  begin errors++; $display("[TB] FAIL glitch_busy: got %b expected 1", busy_o); end
    rx_i = 1'b1;
    repeat (128) @(negedge clk);
    checks++; if (busy_o !== 1'b0)  begin errors++; $display("[TB] FAIL glitch_idle: busy_o=%b expected 0", busy_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL glitch_valid: got %b expected 0", valid_o); end
  endtask

  task automatic test_overrun;
    word_t e; bit ok, eov;
    applyStimulus(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitValid(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ovr_valid: valid_o=%b expected 1", valid_o); end
    popExpected(e, eov);
    checks++; if (data_o !== e.data) begin errors++; $display("[TB] FAIL ovr_data: got %h expected %h", data_o, e.data); end
    checks++; if (overrun_o !== eov) begin errors++; $display("[TB] FAIL ovr_flag: got %b expected %b", overrun_o, eov); end
    readWord();
    checks++; if (valid_o !== 1'b0)   begin errors++; $display("[TB] FAIL ovr_rd_valid: got %b expected 0", valid_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL ovr_rd_flag: got %b expected 0", overrun_o); end
  endtask

  task automatic test_reset_mid_data;
    word_t e; bit ok, eov;
    applyStimulus(8'h77, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    data_bits_i = 2'b11;
    parity_en_i = 1'b0;
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 1", busy_o); end
    reset = 1'b1;
    rx_i  = 1'b1;
    sbQ.delete();
    @(negedge clk);
    checks++; if (data_o !== 8'h00)      begin errors++; $display("[TB] FAIL rst_mid_data: got %h expected 00", data_o); end
    checks++; if (valid_o !== 1'b0)      begin errors++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", valid_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_pe: got %b expected 0", parity_err_o); end
    checks++; if (frame_err_o !== 1'b0)  begin errors++; $display("[TB] FAIL rst_mid_fe: got %b expected 0", frame_err_o); end
    checks++; if (overrun_o !== 1'b0)    begin errors++; $display("[TB] FAIL rst_mid_ov: got %b expected 0", overrun_o); end
    checks++; if (busy_o !== 1'b0)       begin errors++; $display("[TB] FAIL rst_mid_busy0: got %b expected 0", busy_o); end
    reset = 1'b0;
    repeat (8) @(negedge clk);
    applyStimulus(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitValid(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_5a_valid: valid_o=%b expected 1", valid_o); end
    popExpected(e, eov);
    checks++; if (data_o !== e.data)  begin errors++; $display("[TB] FAIL rst_5a_data: got %h expected %h", data_o, e.data); end
    checks++; if (overrun_o !== eov)  begin errors++; $display("[TB] FAIL rst_5a_ov: got %b expected %b", overrun_o, eov); end
    readWord();
  endtask

  task automatic test_back_to_back;
    word_t e; bit ok, eov;
    logic [7:0] d;
    int nb;
    logic pen, podd, bad;
    for (int k = 0; k < 4; k++) begin
      d    = 8'($urandom);
      nb   = 5 + int'($urandom_range(0, 3));
      pen  = 1'($urandom);
      podd = 1'($urandom);
      bad  = 1'($urandom);
      applyStimulus(d, nb, pen, podd, bad, 1'b1, (k == 2));
      waitValid(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b%0d_valid: valid_o=%b expected 1", k, valid_o); end
      popExpected(e, eov);
      checks++; if (data_o !== e.data)     begin errors++; $display("[TB] FAIL b2b%0d_data: got %h expected %h", k, data_o, e.data); end
      checks++; if (parity_err_o !== e.pe) begin errors++; $display("[TB] FAIL b2b%0d_pe: got %b expected %b", k, parity_err_o, e.pe); end
      checks++; if (overrun_o !== eov)     begin errors++; $display("[TB] FAIL b2b%0d_ov: got %b expected %b", k, overrun_o, eov); end
      readWord();
    end
  endtask

  initial begin
    reset        = 1'b1;
    rx_i         = 1'b1;
    rd_i         = 1'b0;
    data_bits_i  = 2'b11;
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    @(negedge clk);
    $display("[TB] starting uart_rx bench");
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid_data();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
